// File: rtl/dcache_dram_manager_if.sv
// Port bundle of the data-cache RAM manager: read pipe, LSU write, maintenance op,
// refill burst bus and RAM-write snoop. The manager takes the slave modport.
interface dcache_dram_manager_if #(
    parameter int TAG_LEN    = 20,
    parameter int IDX_LEN    = 12,
    parameter int LINE_WORDS = 4
);
    localparam int TW  = TAG_LEN + 1;
    localparam int OFS = $clog2(LINE_WORDS) + 2;
    localparam int LA  = IDX_LEN - OFS;
    localparam int DA  = IDX_LEN - 2;

    logic          rd_valid_i;
    logic [31:0]   rd_addr_i;
    logic [TW-1:0] rd_tag_o;
    logic [31:0]   rd_data_o;
    logic          rd_valid_o;
    logic          pending_write_o;

    logic          wr_valid_i;
    logic [31:0]   wr_addr_i;
    logic [31:0]   wr_data_i;
    logic          wr_ready_o;

    logic          op_valid_i;
    logic [3:0]    op_type_i;
    logic [31:0]   op_addr_i;
    logic          op_ready_o;

    logic          bus_req_o;
    logic [31:0]   bus_addr_o;
    logic          bus_ready_i;
    logic          bus_rvalid_i;
    logic [31:0]   bus_rdata_i;

    logic          snp_tag_we_o;
    logic [LA-1:0] snp_tag_waddr_o;
    logic [TW-1:0] snp_tag_wdata_o;
    logic          snp_data_we_o;
    logic [DA-1:0] snp_data_waddr_o;
    logic [31:0]   snp_data_wdata_o;

    modport slave (
        input  rd_valid_i, rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i,
               op_valid_i, op_type_i, op_addr_i, bus_ready_i, bus_rvalid_i, bus_rdata_i,
        output rd_tag_o, rd_data_o, rd_valid_o, pending_write_o, wr_ready_o, op_ready_o,
               bus_req_o, bus_addr_o, snp_tag_we_o, snp_tag_waddr_o, snp_tag_wdata_o,
               snp_data_we_o, snp_data_waddr_o, snp_data_wdata_o
    );

    modport master (
        output rd_valid_i, rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i,
               op_valid_i, op_type_i, op_addr_i, bus_ready_i, bus_rvalid_i, bus_rdata_i,
        input  rd_tag_o, rd_data_o, rd_valid_o, pending_write_o, wr_ready_o, op_ready_o,
               bus_req_o, bus_addr_o, snp_tag_we_o, snp_tag_waddr_o, snp_tag_wdata_o,
               snp_data_we_o, snp_data_waddr_o, snp_data_wdata_o
    );
endinterface

// File: rtl/dcache_dram_manager.sv
// Direct-mapped D-cache tag/data RAM owner: read pipe, LSU writes, refill and invalidate.
// Optional one-entry write buffer enabled by defining DCACHE_WRITE_BUFFER_EN.
module dcache_dram_manager #(
    parameter int TAG_LEN    = 20,
    parameter int IDX_LEN    = 12,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dcache_dram_manager_if.slave  io
);
    localparam int TW  = TAG_LEN + 1;
    localparam int BW  = $clog2(LINE_WORDS);
    localparam int OFS = BW + 2;
    localparam int LA  = IDX_LEN - OFS;
    localparam int DA  = IDX_LEN - 2;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_REFILL_REQ, S_REFILL_DATA, S_TAG_WB} state_t;

    state_t        r_state, w_state_nxt;
    logic [LA-1:0] r_sweep;
    logic [BW-1:0] r_beat;
    logic [31:OFS] r_addr;
    logic          r_rd_valid;
    logic [LA-1:0] r_rd_idx;
    logic [TW-1:0] r_rd_tag;
    logic [31:0]   r_rd_data;

    logic [TW-1:0] r_tag_ram  [0:(1<<LA)-1];
    logic [31:0]   r_data_ram [0:(1<<DA)-1];

    logic          w_tag_we, w_data_we;
    logic [LA-1:0] w_tag_waddr;
    logic [TW-1:0] w_tag_wdata;
    logic [DA-1:0] w_data_waddr;
    logic [31:0]   w_data_wdata;
    logic          w_wr_ready, w_op_ready, w_bus_req;
    logic [31:0]   w_bus_addr;
    logic          w_buf_pend;

    wire [LA-1:0] w_rd_tidx = io.rd_addr_i[OFS +: LA];
    wire [DA-1:0] w_rd_didx = io.rd_addr_i[2 +: DA];

`ifdef DCACHE_WRITE_BUFFER_EN
    logic          r_buf_full;
    logic [DA-1:0] r_buf_addr;
    logic [31:0]   r_buf_data;
    logic          w_buf_push, w_buf_pop;
    assign w_buf_pend = r_buf_full;
`else
    assign w_buf_pend = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_tag_we     = 1'b0;
        w_tag_waddr  = '0;
        w_tag_wdata  = '0;
        w_data_we    = 1'b0;
        w_data_waddr = '0;
        w_data_wdata = '0;
        w_wr_ready   = 1'b0;
        w_op_ready   = 1'b0;
        w_bus_req    = 1'b0;
        w_bus_addr   = '0;
`ifdef DCACHE_WRITE_BUFFER_EN
        w_buf_push   = 1'b0;
        w_buf_pop    = 1'b0;
`endif
        case (r_state)
            S_INIT: begin
                w_tag_we    = 1'b1;
                w_tag_waddr = r_sweep;
                if (&r_sweep) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                w_op_ready = 1'b1;
`ifdef DCACHE_WRITE_BUFFER_EN
                // a held write owns the data port for this cycle
                w_wr_ready = !r_buf_full;
                if (r_buf_full) begin
                    w_data_we    = 1'b1;
                    w_data_waddr = r_buf_addr;
                    w_data_wdata = r_buf_data;
                    w_buf_pop    = 1'b1;
                end else if (io.wr_valid_i) begin
                    w_data_we    = 1'b1;
                    w_data_waddr = io.wr_addr_i[2 +: DA];
                    w_data_wdata = io.wr_data_i;
                end
`else
                w_wr_ready = 1'b1;
                if (io.wr_valid_i) begin
                    w_data_we    = 1'b1;
                    w_data_waddr = io.wr_addr_i[2 +: DA];
                    w_data_wdata = io.wr_data_i;
                end
`endif
                if (io.op_valid_i) begin
                    if (io.op_type_i == 4'd1) begin
                        w_state_nxt = S_REFILL_REQ;
                    end else if (io.op_type_i == 4'd2) begin
                        w_tag_we    = 1'b1;
                        w_tag_waddr = io.op_addr_i[OFS +: LA];
                    end
                end
            end
            S_REFILL_REQ: begin
                w_bus_req  = 1'b1;
                w_bus_addr = {r_addr, {OFS{1'b0}}};
                if (io.bus_ready_i) w_state_nxt = S_REFILL_DATA;
            end
            S_REFILL_DATA: begin
                if (io.bus_rvalid_i) begin
                    w_data_we    = 1'b1;
                    w_data_waddr = {r_addr[OFS +: LA], r_beat};
                    w_data_wdata = io.bus_rdata_i;
                    if (r_beat == BW'(LINE_WORDS - 1)) w_state_nxt = S_TAG_WB;
                end
            end
            S_TAG_WB: begin
                w_tag_we    = 1'b1;
                w_tag_waddr = r_addr[OFS +: LA];
                w_tag_wdata = {1'b1, r_addr[IDX_LEN +: TAG_LEN]};
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_INIT;
        endcase
`ifdef DCACHE_WRITE_BUFFER_EN
        if (r_state != S_INIT && r_state != S_IDLE) begin
            w_wr_ready = !r_buf_full;
            w_buf_push = io.wr_valid_i && !r_buf_full;
        end
`endif
        // keep the RAMs and snoop quiet while reset is held
        if (!rst_n) begin
            w_tag_we  = 1'b0;
            w_data_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_INIT;
            r_sweep    <= '0;
            r_beat     <= '0;
            r_addr     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_idx   <= '0;
            r_rd_tag   <= '0;
            r_rd_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT) r_sweep <= r_sweep + 1'b1;
            if (r_state == S_REFILL_DATA && io.bus_rvalid_i) r_beat <= r_beat + 1'b1;
            if (r_state == S_IDLE && io.op_valid_i && io.op_type_i == 4'd1)
                r_addr <= io.op_addr_i[31:OFS];
            r_rd_valid <= io.rd_valid_i && (r_state != S_INIT);
            r_rd_idx   <= w_rd_tidx;
            if (io.rd_valid_i) begin
                r_rd_tag  <= (w_tag_we && w_tag_waddr == w_rd_tidx) ? w_tag_wdata : r_tag_ram[w_rd_tidx];
                r_rd_data <= (w_data_we && w_data_waddr == w_rd_didx) ? w_data_wdata : r_data_ram[w_rd_didx];
            end
        end
    end

`ifdef DCACHE_WRITE_BUFFER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_full <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
        end else if (w_buf_push) begin
            r_buf_full <= 1'b1;
            r_buf_addr <= io.wr_addr_i[2 +: DA];
            r_buf_data <= io.wr_data_i;
        end else if (w_buf_pop) begin
            r_buf_full <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (w_tag_we)  r_tag_ram[w_tag_waddr]   <= w_tag_wdata;
        if (w_data_we) r_data_ram[w_data_waddr] <= w_data_wdata;
    end

    assign io.rd_valid_o       = r_rd_valid;
    assign io.rd_tag_o         = r_rd_tag;
    assign io.rd_data_o        = r_rd_data;
    assign io.pending_write_o  = rst_n && ((r_state != S_IDLE) || w_buf_pend ||
                                 (r_rd_valid && ((w_tag_we && w_tag_waddr == r_rd_idx) ||
                                                 (w_data_we && w_data_waddr[DA-1:BW] == r_rd_idx))));
    assign io.wr_ready_o       = w_wr_ready;
    assign io.op_ready_o       = w_op_ready;
    assign io.bus_req_o        = w_bus_req;
    assign io.bus_addr_o       = w_bus_addr;
    assign io.snp_tag_we_o     = w_tag_we;
    assign io.snp_tag_waddr_o  = w_tag_waddr;
    assign io.snp_tag_wdata_o  = w_tag_wdata;
    assign io.snp_data_we_o    = w_data_we;
    assign io.snp_data_waddr_o = w_data_waddr;
    assign io.snp_data_wdata_o = w_data_wdata;

    logic w_unused;
    assign w_unused = &{1'b0, io.rd_addr_i[31:IDX_LEN], io.rd_addr_i[1:0],
                        io.wr_addr_i[31:IDX_LEN], io.wr_addr_i[1:0], io.op_addr_i[OFS-1:0]};
endmodule

// File: tb/tb_dcache_dram_manager.sv
// Self-checking bench for dcache_dram_manager: table-driven reads/writes/ops with a
// read scoreboard, plus hand sequences for sweep, refill, bypass, invalidate and reset.
module tb_dcache_dram_manager;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_dram_manager_if ifc();
    dcache_dram_manager dut (.clk(clk), .rst_n(rst_n), .io(ifc));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [20:0] tag;
        logic [31:0] data;
        bit          cd;
    } rd_exp_t;
    rd_exp_t sb[$];

    typedef enum {V_RD, V_WR, V_OP} vk_t;
    typedef struct {
        vk_t         k;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  op;
        logic [20:0] t;
        bit          cd;
    } vec_t;
    vec_t tbl[12];

`ifdef DCACHE_WRITE_BUFFER_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        rd_exp_t e;
        if (rst_n && ifc.rd_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got rd_valid_o=1 want no read outstanding");
            end else begin
                e = sb.pop_front();
                chk("rd_tag", 64'(ifc.rd_tag_o), 64'(e.tag));
                if (e.cd) chk("rd_data", 64'(ifc.rd_data_o), 64'(e.data));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    task automatic clr_in();
        ifc.rd_valid_i = 0; ifc.rd_addr_i = 0;
        ifc.wr_valid_i = 0; ifc.wr_addr_i = 0; ifc.wr_data_i = 0;
        ifc.op_valid_i = 0; ifc.op_type_i = 0; ifc.op_addr_i = 0;
        ifc.bus_ready_i = 0; ifc.bus_rvalid_i = 0; ifc.bus_rdata_i = 0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [20:0] t, input logic [31:0] d, input bit cd);
        rd_exp_t e;
        ifc.rd_valid_i = 1'b1;
        ifc.rd_addr_i  = a;
        e.tag = t; e.data = d; e.cd = cd;
        sb.push_back(e);
    endtask

    // Called right after rst_n rises at a negedge; ends in the first IDLE cycle.
    task automatic sweep_check();
        ifc.rd_valid_i = 1'b1;
        ifc.rd_addr_i  = 32'h0000_0040;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ia;
            ia = 8'(i);
            #1;
            chk("sweep", {31'h0, ifc.snp_tag_we_o, ifc.snp_tag_waddr_o, ifc.snp_tag_wdata_o,
                          ifc.wr_ready_o, ifc.op_ready_o, ifc.rd_valid_o},
                         {31'h0, 1'b1, ia, 21'h0, 3'b000});
            @(negedge clk);
        end
        rd(32'h0000_0040, 21'h0, 32'h0, 1'b0);
        #1 chk("idle_ready", {62'h0, ifc.wr_ready_o, ifc.op_ready_o}, 64'h3);
        @(negedge clk);
        ifc.rd_valid_i = 1'b0;
    endtask

    task automatic refill(input logic [31:0] a, input logic [31:0] b0, input int nb,
                          input bit wr_mid, input logic [31:0] wa, input logic [31:0] wd);
        logic [7:0]  li;
        logic [31:0] la;
        li = a[11:4];
        la = {a[31:4], 4'h0};
        ifc.op_valid_i = 1'b1; ifc.op_type_i = 4'd1; ifc.op_addr_i = a;
        #1 chk("refill_op_ready", 64'(ifc.op_ready_o), 64'h1);
        @(negedge clk);
        ifc.op_valid_i = 1'b0;
        // stalled request; a stray beat here must not reach the RAM
        ifc.bus_rvalid_i = 1'b1; ifc.bus_rdata_i = 32'hBAD0_BAD0;
        #1 chk("req", {29'h0, ifc.bus_req_o, ifc.bus_addr_o, ifc.snp_data_we_o, ifc.pending_write_o},
                      {29'h0, 1'b1, la, 1'b0, 1'b1});
        @(negedge clk);
        ifc.bus_rvalid_i = 1'b0; ifc.bus_ready_i = 1'b1;
        #1 chk("req_hold", {31'h0, ifc.bus_req_o, ifc.bus_addr_o}, {31'h0, 1'b1, la});
        @(negedge clk);
        ifc.bus_ready_i = 1'b0;
        for (int n = 0; n < nb; n++) begin
            logic [1:0] bn;
            bn = 2'(n);
            ifc.bus_rvalid_i = 1'b1; ifc.bus_rdata_i = b0 + 32'(n);
            if (wr_mid && n == 1) begin
                ifc.wr_valid_i = 1'b1; ifc.wr_addr_i = wa; ifc.wr_data_i = wd;
            end
            #1 chk("beat", {20'h0, ifc.snp_data_we_o, ifc.snp_data_waddr_o, ifc.snp_data_wdata_o, ifc.bus_req_o},
                           {20'h0, 1'b1, li, bn, b0 + 32'(n), 1'b0});
            if (wr_mid && n == 1) chk("wr_ready_refill", 64'(ifc.wr_ready_o), 64'(WB));
            @(negedge clk);
            if (WB && wr_mid && n == 1) ifc.wr_valid_i = 1'b0;
        end
        ifc.bus_rvalid_i = 1'b0;
        if (nb < 4) return;
        #1 chk("tag_wb", {33'h0, ifc.snp_tag_we_o, ifc.snp_tag_waddr_o, ifc.snp_tag_wdata_o, ifc.wr_ready_o},
                         {33'h0, 1'b1, li, 1'b1, a[31:12], WB && !wr_mid});
        @(negedge clk);
        if (wr_mid) begin
            #1 chk("wr_first_idle", {21'h0, ifc.wr_ready_o, ifc.snp_data_we_o, ifc.snp_data_waddr_o, ifc.snp_data_wdata_o},
                                    {21'h0, !WB, 1'b1, wa[11:2], wd});
            @(negedge clk);
            ifc.wr_valid_i = 1'b0;
        end
    endtask

    initial begin
        tbl[0]  = '{V_RD, 32'h1234_5678, 32'h0000_00A2, 4'd0, 21'h112345, 1'b1};
        tbl[1]  = '{V_RD, 32'h1234_5670, 32'h0000_00A0, 4'd0, 21'h112345, 1'b1};
        tbl[2]  = '{V_RD, 32'h1234_567C, 32'h0000_00A3, 4'd0, 21'h112345, 1'b1};
        tbl[3]  = '{V_RD, 32'h1234_5674, 32'h5555_5555, 4'd0, 21'h112345, 1'b1};
        tbl[4]  = '{V_WR, 32'h1234_567C, 32'h1111_1111, 4'd0, 21'h0,      1'b0};
        tbl[5]  = '{V_RD, 32'h1234_567C, 32'h1111_1111, 4'd0, 21'h112345, 1'b1};
        tbl[6]  = '{V_RD, 32'h0000_0040, 32'h0,         4'd0, 21'h0,      1'b0};
        tbl[7]  = '{V_RD, 32'hABCD_E678, 32'h0000_00A2, 4'd0, 21'h112345, 1'b1};
        tbl[8]  = '{V_OP, 32'h1234_5670, 32'h0,         4'd5, 21'h0,      1'b0};
        tbl[9]  = '{V_RD, 32'h1234_5670, 32'h0000_00A0, 4'd0, 21'h112345, 1'b1};
        tbl[10] = '{V_WR, 32'h0000_0FFC, 32'hCAFE_F00D, 4'd0, 21'h0,      1'b0};
        tbl[11] = '{V_RD, 32'h0000_0FFC, 32'hCAFE_F00D, 4'd0, 21'h0,      1'b1};

        clr_in();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_a", {6'h0, ifc.rd_valid_o, ifc.rd_tag_o, ifc.rd_data_o, ifc.pending_write_o,
                        ifc.wr_ready_o, ifc.op_ready_o, ifc.bus_req_o}, 64'h0);
        chk("reset_b", {12'h0, ifc.bus_addr_o, ifc.snp_tag_we_o, ifc.snp_tag_waddr_o,
                        ifc.snp_data_we_o, ifc.snp_data_waddr_o}, 64'h0);
        chk("reset_c", {11'h0, ifc.snp_tag_wdata_o, ifc.snp_data_wdata_o}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check();

        // refill with an LSU write to the same line arriving mid-burst
        refill(32'h1234_5670, 32'hA0, 4, 1'b1, 32'h1234_5674, 32'h5555_5555);

        for (int i = 0; i < 12; i++) begin
            int w;
            w = 0;
            case (tbl[i].k)
                V_RD: begin
                    rd(tbl[i].a, tbl[i].t, tbl[i].d, tbl[i].cd);
                    @(negedge clk);
                    ifc.rd_valid_i = 1'b0;
                end
                V_WR: begin
                    ifc.wr_valid_i = 1'b1; ifc.wr_addr_i = tbl[i].a; ifc.wr_data_i = tbl[i].d;
                    #1;
                    while (!ifc.wr_ready_o && w < 8) begin @(negedge clk); #1; w++; end
                    chk("tbl_wr_ready", 64'(ifc.wr_ready_o), 64'h1);
                    @(negedge clk);
                    ifc.wr_valid_i = 1'b0;
                end
                default: begin
                    ifc.op_valid_i = 1'b1; ifc.op_type_i = tbl[i].op; ifc.op_addr_i = tbl[i].a;
                    #1;
                    while (!ifc.op_ready_o && w < 8) begin @(negedge clk); #1; w++; end
                    chk("tbl_op_ready", 64'(ifc.op_ready_o), 64'h1);
                    @(negedge clk);
                    ifc.op_valid_i = 1'b0;
                end
            endcase
        end

        // write-first bypass, write held one more cycle so it targets the line just read
        ifc.wr_valid_i = 1'b1; ifc.wr_addr_i = 32'h1234_5674; ifc.wr_data_i = 32'hDEAD_BEEF;
        rd(32'h1234_5674, 21'h112345, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        ifc.rd_valid_i = 1'b0;
        #1 chk("pending_bypass", 64'(ifc.pending_write_o), 64'h1);
        @(negedge clk);
        ifc.wr_valid_i = 1'b0;
        #1 chk("pending_quiet", 64'(ifc.pending_write_o), 64'h0);
        rd(32'h1234_5674, 21'h112345, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        ifc.rd_valid_i = 1'b0;
        @(negedge clk);

        // reset in the middle of a refill, after two beats
        refill(32'h1234_5670, 32'hB0, 2, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1 chk("rst_mid", {59'h0, ifc.bus_req_o, ifc.snp_tag_we_o, ifc.snp_data_we_o,
                           ifc.op_ready_o, ifc.rd_valid_o}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check();
        rd(32'h1234_5670, 21'h0, 32'h0000_00B0, 1'b1);
        @(negedge clk);
        ifc.rd_valid_i = 1'b0;

        // full refill, then invalidate alongside an unrelated write
        refill(32'h1234_5670, 32'hC0, 4, 1'b0, 32'h0, 32'h0);
        rd(32'h1234_5670, 21'h112345, 32'h0000_00C0, 1'b1);
        @(negedge clk);
        ifc.rd_valid_i = 1'b0;
        ifc.op_valid_i = 1'b1; ifc.op_type_i = 4'd2; ifc.op_addr_i = 32'h1234_5670;
        ifc.wr_valid_i = 1'b1; ifc.wr_addr_i = 32'h0000_1000; ifc.wr_data_i = 32'h0000_0077;
        #1 chk("inv_wr_tag", {34'h0, ifc.snp_tag_we_o, ifc.snp_tag_waddr_o, ifc.snp_tag_wdata_o},
                             {34'h0, 1'b1, 8'h67, 21'h0});
        chk("inv_wr_data", {21'h0, ifc.snp_data_we_o, ifc.snp_data_waddr_o, ifc.snp_data_wdata_o},
                           {21'h0, 1'b1, 10'h0, 32'h77});
        @(negedge clk);
        clr_in();
        rd(32'h1234_5670, 21'h0, 32'h0000_00C0, 1'b1);
        @(negedge clk);
        rd(32'h0000_1000, 21'h0, 32'h0000_0077, 1'b1);
        @(negedge clk);
        ifc.rd_valid_i = 1'b0;
        repeat (3) @(negedge clk);

        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
